alu_rmw_sequencer: RTL and testbench
====================================

ALU_RMW_SEQUENCER -- requirements
Module: alu_rmw_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to begin one read-modify-write; sampled only in IDLE.
REQ-005 op  input  3  operation: 0 ASL, 1 LSR, 2 ROL, 3 ROR, 4 INC, 5 DEC, 6-7 illegal.
REQ-006 addr  input  16  target memory address; sampled with start.
REQ-007 carry_in  input  1  current C flag; sampled with start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse on completion.
REQ-010 illegal  output  1  one-cycle pulse when start is given with op 6 or 7.
REQ-011 mem_req, mem_we  output  1 each  memory request and write enable.
REQ-012 mem_addr  output  16  latched target address.
REQ-013 mem_wdata  output  8  write data.
REQ-014 mem_rdata  input  8  read data, valid when mem_ack=1.
REQ-015 mem_ack  input  1  completes the current request in the cycle it is high with mem_req=1.
REQ-016 alu_bi  output  8  ALU B operand (latched operand register).
REQ-017 alu_uop  output  4  ALU micro-op, using the shared uop constants.
REQ-018 alu_carry_in  output  1  latched carry_in.
REQ-019 alu_result  input  8  combinational ALU result.
REQ-020 alu_carry_out  input  1  combinational ALU carry.
REQ-021 flag_n, flag_z, flag_c  output  1 each  registered result flags.
REQ-022 flags_we  output  1  one-cycle pulse, coincident with done, meaning the flag outputs are to be committed.

Function
REQ-023 States SHALL be IDLE, READ, MODIFY, DUMMY_WR, WRITE and DONE.
REQ-024 IDLE: start with op 0-5 SHALL latch op, addr and carry_in and go to READ; start with op 6-7 SHALL pulse illegal for one cycle and stay in IDLE with no memory access.
REQ-025 READ: mem_req=1 and mem_we=0; on mem_ack, mem_rdata SHALL be latched into the operand register and the FSM SHALL go to MODIFY; otherwise it stays in READ.
REQ-026 MODIFY: one cycle; alu_uop SHALL be ASL->SHIFT_LEFT_BI, LSR->SHIFT_RIGHT_BI, ROL->ROTATE_LEFT_BI, ROR->ROTATE_RIGHT_BI, INC->INCREMENT, DEC->DECREMENT.
REQ-027 MODIFY: alu_result SHALL be latched into the result register and alu_carry_out into the carry register; next state is DUMMY_WR.
REQ-028 Outside MODIFY, alu_uop SHALL be PASS_BI; alu_bi SHALL always equal the operand register.
REQ-029 DUMMY_WR: mem_req=1, mem_we=1, mem_wdata=original operand; on mem_ack go to WRITE.
REQ-030 WRITE: mem_req=1, mem_we=1, mem_wdata=result; on mem_ack go to DONE.
REQ-031 DONE: done=1 and flags_we=1 for exactly one cycle, then go to IDLE.
REQ-032 Flags SHALL be flag_n=result[7] and flag_z=(result==0); they are registered and valid from the DONE cycle until the next DONE.
REQ-033 flag_c SHALL be the latched ALU carry for ops 0-3, and the latched carry_in (unchanged) for INC/DEC.
REQ-034 INC/DEC SHALL wrap modulo 256 (0xFF+1=0x00, 0x00-1=0xFF).
REQ-035 mem_addr SHALL hold the latched address, stable for the whole operation; while mem_req=0, mem_we=0.
REQ-036 mem_ack SHALL be ignored when mem_req=0; start SHALL be ignored while busy=1.
REQ-037 mem_req SHALL be held high with address, we and wdata constant until ack.
REQ-038 With zero-wait ack (ack in the first request cycle), done SHALL assert 5 cycles after the start-accept edge; each wait cycle adds one.

Reset
REQ-039 rst SHALL force IDLE and clear all outputs and internal registers to 0 on the next clock edge, overriding all other inputs.
REQ-040 rst mid-operation SHALL drop mem_req the following cycle and produce no done, flags_we or write of the result.
REQ-041 The first start after rst is deasserted SHALL be accepted normally.

Verification
REQ-042 ASL, addr 0x0200, mem=0x81, carry_in=0, zero-wait -> writes 0x81 then 0x02 to 0x0200; done at cycle 5; N=0 Z=0 C=1.
REQ-043 ROR, mem=0x01, carry_in=1 -> final write 0x80; N=1 Z=0 C=1.
REQ-044 INC, mem=0xFF, carry_in=1 -> final write 0x00; Z=1 N=0 C=1 (unchanged); DEC on 0x00 -> 0xFF, N=1.
REQ-045 LSR with read ack delayed 3 cycles -> mem_req/addr held stable through the wait; done at cycle 8.
REQ-046 start during busy is ignored; op=6 -> illegal pulse, no mem_req, busy stays 0.
REQ-047 rst during DUMMY_WR -> next cycle busy=0, mem_req=0, all flags 0, no done, no result write.

Source files
------------

// File: rtl/alu_rmw_sequencer.sv
// Read-modify-write sequencer for 6502-style memory operand instructions
// (ASL, LSR, ROL, ROR, INC, DEC). Reads the operand, drives an external ALU
// for one cycle, writes the original value back (dummy write), then writes the
// result and commits N/Z/C flags.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; op 6-7 only pulses illegal
// READ     | memory read of the target address until mem_ack
// MODIFY   | one cycle; ALU computes result, result and carry latched
// DUMMY_WR | write back the original operand until mem_ack
// WRITE    | write the ALU result until mem_ack
// DONE     | one-cycle done / flags_we pulse, flags already registered
module alu_rmw_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] addr,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [7:0]  alu_bi,
  output logic [3:0]  alu_uop,
  output logic        alu_carry_in,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry_out,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flags_we
);

  // ALU micro-op encoding shared with the datapath ALU
  localparam logic [3:0] UOP_PASS_BI         = 4'd0;
  localparam logic [3:0] UOP_SHIFT_LEFT_BI   = 4'd1;
  localparam logic [3:0] UOP_SHIFT_RIGHT_BI  = 4'd2;
  localparam logic [3:0] UOP_ROTATE_LEFT_BI  = 4'd3;
  localparam logic [3:0] UOP_ROTATE_RIGHT_BI = 4'd4;
  localparam logic [3:0] UOP_INCREMENT       = 4'd5;
  localparam logic [3:0] UOP_DECREMENT       = 4'd6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    MODIFY   = 3'd2,
    DUMMY_WR = 3'd3,
    WRITE    = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic        cin_q;
  logic [7:0]  operand_q;
  logic [7:0]  result_q;
  logic        carry_q;

  assign alu_bi       = operand_q;
  assign alu_carry_in = cin_q;

  function automatic logic [3:0] uop_for(input logic [2:0] o);
    logic [3:0] u;
    u = UOP_PASS_BI;
    case (o)
      3'd0:    u = UOP_SHIFT_LEFT_BI;
      3'd1:    u = UOP_SHIFT_RIGHT_BI;
      3'd2:    u = UOP_ROTATE_LEFT_BI;
      3'd3:    u = UOP_ROTATE_RIGHT_BI;
      3'd4:    u = UOP_INCREMENT;
      3'd5:    u = UOP_DECREMENT;
      default: u = UOP_PASS_BI;
    endcase
    return u;
  endfunction

  // Sequencer FSM; every output is registered and updated on the state transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= 3'd0;
      cin_q     <= 1'b0;
      operand_q <= 8'd0;
      result_q  <= 8'd0;
      carry_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'd0;
      mem_wdata <= 8'd0;
      alu_uop   <= UOP_PASS_BI;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flags_we  <= 1'b0;
    end else begin
      done     <= 1'b0;
      flags_we <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op >= 3'd6) begin
              illegal <= 1'b1;
            end else begin
              op_q     <= op;
              mem_addr <= addr;
              cin_q    <= carry_in;
              busy     <= 1'b1;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              state    <= READ;
            end
          end
        end
        READ: begin
          if (mem_ack) begin
            operand_q <= mem_rdata;
            mem_req   <= 1'b0;
            alu_uop   <= uop_for(op_q);
            state     <= MODIFY;
          end
        end
        MODIFY: begin
          result_q  <= alu_result;
          carry_q   <= alu_carry_out;
          alu_uop   <= UOP_PASS_BI;
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_wdata <= operand_q;
          state     <= DUMMY_WR;
        end
        DUMMY_WR: begin
          if (mem_ack) begin
            mem_wdata <= result_q;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'd0;
            flag_n    <= result_q[7];
            flag_z    <= (result_q == 8'd0);
            // INC/DEC leave C untouched, shifts/rotates take the ALU carry
            flag_c    <= (op_q <= 3'd3) ? carry_q : cin_q;
            done      <= 1'b1;
            flags_we  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          alu_uop <= UOP_PASS_BI;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rmw_sequencer.sv
// Scoreboard bench for alu_rmw_sequencer: the driver pushes the expected
// writes and flags per operation, a monitor pops them as the DUT writes and
// completes. A behavioural ALU and a memory responder with configurable wait
// states sit around the DUT.
module tb_alu_rmw_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] addr;
  logic        carry_in;
  logic        busy, done, illegal;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [7:0]  alu_bi;
  logic [3:0]  alu_uop;
  logic        alu_carry_in;
  logic [7:0]  alu_result;
  logic        alu_carry_out;
  logic        flag_n, flag_z, flag_c, flags_we;

  alu_rmw_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .carry_in(carry_in),
    .busy(busy), .done(done), .illegal(illegal),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_bi(alu_bi), .alu_uop(alu_uop), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flags_we(flags_we)
  );

  always #5 clk = ~clk;

  // external ALU, driven by micro-op
  always_comb begin
    alu_result    = alu_bi;
    alu_carry_out = 1'b0;
    case (alu_uop)
      4'd1: begin alu_result = {alu_bi[6:0], 1'b0};         alu_carry_out = alu_bi[7]; end
      4'd2: begin alu_result = {1'b0, alu_bi[7:1]};         alu_carry_out = alu_bi[0]; end
      4'd3: begin alu_result = {alu_bi[6:0], alu_carry_in}; alu_carry_out = alu_bi[7]; end
      4'd4: begin alu_result = {alu_carry_in, alu_bi[7:1]}; alu_carry_out = alu_bi[0]; end
      4'd5: {alu_carry_out, alu_result} = {1'b0, alu_bi} + 9'd1;
      4'd6: {alu_carry_out, alu_result} = {1'b0, alu_bi} - 9'd1;
      default: ;
    endcase
  end

  typedef struct {
    logic [15:0] a;
    logic [7:0]  orig;
    logic [7:0]  res;
    logic        n, z, c;
  } exp_t;

  exp_t sb[$];
  int   wr_idx = 0;
  int   checks = 0;
  int   passes = 0;
  logic exp_illegal = 1'b0;

  // memory responder settings
  logic [7:0] mem_value = 8'h00;
  int  rd_wait = 0, wr_wait = 0;
  bit  rand_wait = 1'b0;
  int  wait_left = 0;
  bit  in_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference model computed from the instruction semantics
  function automatic exp_t model(input int o, input int a, input int m, input int c);
    exp_t e;
    int r, cf;
    case (o)
      0: begin r = (m * 2) % 256;            cf = m / 128; end
      1: begin r = m / 2;                    cf = m % 2;   end
      2: begin r = (m * 2) % 256 + c;        cf = m / 128; end
      3: begin r = m / 2 + c * 128;          cf = m % 2;   end
      4: begin r = (m + 1) % 256;            cf = c;       end
      default: begin r = (m + 255) % 256;    cf = c;       end
    endcase
    e.a    = a[15:0];
    e.orig = m[7:0];
    e.res  = r[7:0];
    e.n    = (r >= 128);
    e.z    = (r == 0);
    e.c    = cf[0];
    return e;
  endfunction

  // memory responder: ack after the configured number of wait cycles per request
  always @(negedge clk) begin
    if (mem_ack) in_req = 1'b0;
    mem_ack = 1'b0;
    if (mem_req && !rst) begin
      if (!in_req) begin
        in_req = 1'b1;
        wait_left = rand_wait ? int'($urandom_range(0, 2)) : (mem_we ? wr_wait : rd_wait);
      end
      if (wait_left == 0) mem_ack = 1'b1;
      else wait_left--;
    end else begin
      in_req = 1'b0;
    end
    mem_rdata = mem_value;
  end

  // monitor: compares writes and completions against the scoreboard
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (!mem_req) check("we_without_req", mem_we, 1'b0);
      if (mem_req && sb.size() > 0) check("mem_addr", mem_addr, sb[0].a);
      if (illegal || exp_illegal) check("illegal_pulse", illegal, exp_illegal);
      if (done || flags_we) check("flags_we_with_done", flags_we, done);
      if (mem_req && mem_we && mem_ack) begin
        check("write_has_txn", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          check("write_count", wr_idx < 2, 1'b1);
          check(wr_idx == 0 ? "dummy_wdata" : "result_wdata", mem_wdata,
                wr_idx == 0 ? sb[0].orig : sb[0].res);
          wr_idx++;
        end
      end
      if (done) begin
        check("done_has_txn", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          check("writes_before_done", wr_idx, 2);
          check("flag_n", flag_n, sb[0].n);
          check("flag_z", flag_z, sb[0].z);
          check("flag_c", flag_c, sb[0].c);
          void'(sb.pop_front());
        end
        wr_idx = 0;
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 100) begin @(negedge clk); g++; end
    check("idle_before_issue", busy, 1'b0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [7:0] m,
                       input logic c);
    mem_value = m; op = o; addr = a; carry_in = c; start = 1'b1;
    sb.push_back(model(int'(o), int'(a), int'(m), int'(c)));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // one full operation; lat counts cycles from the accept edge to done
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [7:0] m,
                        input logic c, input bit poke, output int lat);
    wait_idle();
    issue(o, a, m, c);
    lat = 1;
    while (!done && lat < 100) begin
      if (poke) begin
        start = 1'b1; op = 3'($urandom_range(0, 7));
        addr = 16'($urandom); carry_in = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_seen", lat < 100, 1'b1);
  endtask

  task automatic do_illegal(input logic [2:0] o);
    wait_idle();
    op = o; addr = 16'($urandom); carry_in = 1'($urandom); start = 1'b1;
    @(posedge clk);
    exp_illegal = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("illegal_high", illegal, 1'b1);
    check("illegal_busy", busy, 1'b0);
    check("illegal_no_req", mem_req, 1'b0);
    @(posedge clk);
    exp_illegal = 1'b0;
    @(negedge clk);
    check("illegal_one_cycle", illegal, 1'b0);
    check("illegal_still_idle", busy | mem_req, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int g;
    rst = 1'b1; start = 1'b0; op = 3'd0; addr = 16'd0; carry_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_flags", {flag_n, flag_z, flag_c, flags_we}, 4'd0);
    check("rst_uop", alu_uop, 4'd0);
    check("rst_mem_addr", mem_addr, 16'd0);

    rd_wait = 0; wr_wait = 0;
    run_op(3'd0, 16'h0200, 8'h81, 1'b0, 1'b0, lat);
    check("asl_latency", lat, 5);
    run_op(3'd3, 16'h0310, 8'h01, 1'b1, 1'b0, lat);
    run_op(3'd4, 16'h00FF, 8'hFF, 1'b1, 1'b0, lat);
    run_op(3'd5, 16'h8000, 8'h00, 1'b0, 1'b0, lat);
    run_op(3'd2, 16'h4444, 8'h80, 1'b1, 1'b0, lat);

    rd_wait = 3;
    run_op(3'd1, 16'hABCD, 8'h03, 1'b0, 1'b0, lat);
    check("lsr_wait_latency", lat, 8);
    rd_wait = 1; wr_wait = 1;
    run_op(3'd0, 16'h1357, 8'h40, 1'b1, 1'b1, lat);
    check("poke_latency", lat, 8);

    rd_wait = 0; wr_wait = 0;
    do_illegal(3'd6);
    do_illegal(3'd7);

    // flags left non-zero so the reset clear is visible
    run_op(3'd5, 16'h2222, 8'h00, 1'b1, 1'b0, lat);
    wait_idle();
    wr_wait = 3;
    issue(3'd0, 16'h1234, 8'h5A, 1'b0);
    g = 0;
    while (!mem_we && g < 20) begin @(negedge clk); g++; end
    check("reached_dummy_wr", mem_we, 1'b1);
    rst = 1'b1;
    sb.delete();
    wr_idx = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_flags", {flag_n, flag_z, flag_c}, 3'd0);
    check("midrst_done", {done, flags_we}, 2'd0);
    repeat (6) @(negedge clk);

    wr_wait = 0;
    run_op(3'd0, 16'h0200, 8'hC3, 1'b0, 1'b0, lat);
    check("after_rst_latency", lat, 5);

    rand_wait = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) do_illegal(3'(6 + $urandom_range(0, 1)));
      else run_op(3'($urandom_range(0, 5)), 16'($urandom), 8'($urandom), 1'($urandom),
                  bit'($urandom_range(0, 1)), lat);
    end
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
